// File: rtl/hazard_pkg.sv
// Shared constants and enums for the hazard/forwarding control block.
package hazard_pkg;

  localparam int NUM_REGS   = 8;
  localparam int WORD_SIZE  = 32;
  localparam int NUM_STAGES = 6;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEM1,
    ST_MEM2,
    ST_WB
  } stage_e;

  typedef enum logic [1:0] {
    HZ_RUN,
    HZ_MEM_WAIT,
    HZ_ERROR
  } hz_state_e;

endpackage

// File: rtl/hazard_scoreboard.sv
// Producer shift table plus nearest-producer match for both Decode sources.
module hazard_scoreboard #(
  parameter int NUM_REGS = 8,
  parameter int DEPTH    = 4,
  localparam int RB      = $clog2(NUM_REGS),
  localparam int SB      = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          adv_i,
  input  logic          ins_valid_i,
  input  logic [RB-1:0] ins_rd_i,
  input  logic          ins_load_i,
  input  logic [RB-1:0] src_x_i,
  input  logic          use_x_i,
  input  logic [RB-1:0] src_y_i,
  input  logic          use_y_i,
  output logic          hit_x_o,
  output logic          load_x_o,
  output logic [SB-1:0] slot_x_o,
  output logic          hit_y_o,
  output logic          load_y_o,
  output logic [SB-1:0] slot_y_o
);
  import hazard_pkg::*;

  logic [DEPTH-1:0]         valid_q;
  logic [DEPTH-1:0]         ld_q;
  logic [DEPTH-1:0][RB-1:0] rd_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      ld_q    <= '0;
      rd_q    <= '0;
    end else if (adv_i) begin
      valid_q <= {valid_q[DEPTH-2:0], ins_valid_i};
      ld_q    <= {ld_q[DEPTH-2:0], ins_load_i};
      rd_q    <= {rd_q[DEPTH-2:0], ins_rd_i};
    end
  end

  // Scan oldest to youngest so the nearest producer wins.
  always_comb begin
    hit_x_o  = 1'b0;
    load_x_o = 1'b0;
    slot_x_o = '0;
    hit_y_o  = 1'b0;
    load_y_o = 1'b0;
    slot_y_o = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (valid_q[i] && rd_q[i] == src_x_i) begin
        hit_x_o  = 1'b1;
        load_x_o = ld_q[i];
        slot_x_o = SB'(i);
      end
      if (valid_q[i] && rd_q[i] == src_y_i) begin
        hit_y_o  = 1'b1;
        load_y_o = ld_q[i];
        slot_y_o = SB'(i);
      end
    end
    if (!use_x_i || src_x_i == RB'(NUM_REGS-1)) begin
      hit_x_o  = 1'b0;
      load_x_o = 1'b0;
      slot_x_o = '0;
    end
    if (!use_y_i || src_y_i == RB'(NUM_REGS-1)) begin
      hit_y_o  = 1'b0;
      load_y_o = 1'b0;
      slot_y_o = '0;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard control: forwarding select, load-use, memory wait,
// flush and timeout, with a saturating stall-cycle counter.
module hazard_unit #(
  parameter int NUM_REGS        = hazard_pkg::NUM_REGS,
  parameter int DEPTH           = 4,
  parameter int LOAD_READY_SLOT = 2,
  parameter int MAX_WAIT        = 15,
  parameter int NUM_STAGES      = hazard_pkg::NUM_STAGES,
  localparam int RB             = $clog2(NUM_REGS),
  localparam int SB             = $clog2(DEPTH),
  localparam int WB             = $clog2(MAX_WAIT+1)
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  dec_valid,
  input  logic [RB-1:0]         dec_rX,
  input  logic [RB-1:0]         dec_rY,
  input  logic                  dec_use_x,
  input  logic                  dec_use_y,
  input  logic                  dec_wb,
  input  logic                  dec_load,
  input  logic                  branch_taken,
  input  logic                  mem_req,
  input  logic                  DataDone,
  output logic [NUM_STAGES-1:0] stall_vec,
  output logic [NUM_STAGES-1:0] bubble_vec,
  output logic                  fwd_x_en,
  output logic                  fwd_y_en,
  output logic [SB-1:0]         fwd_x_slot,
  output logic [SB-1:0]         fwd_y_slot,
  output logic                  mem_timeout,
  output logic [15:0]           stall_cycles
);
  import hazard_pkg::*;

  localparam logic [1:0] S_RUN      = HZ_RUN;
  localparam logic [1:0] S_MEM_WAIT = HZ_MEM_WAIT;
  localparam logic [1:0] S_ERROR    = HZ_ERROR;

  logic [1:0]    state_q, state_d;
  logic [WB-1:0] cnt_q, cnt_d, cnt_inc;
  logic          tmo_q, tmo_d;
  logic [15:0]   scnt_q, scnt_d;

  logic          hit_x, load_x, hit_y, load_y;
  logic [SB-1:0] slot_x, slot_y;
  logic          run, mw, err, pend;
  logic          x_lu, y_lu, flush, lu, adv, ins_valid;

  assign run = state_q == S_RUN;
  assign mw  = state_q == S_MEM_WAIT;
  assign err = state_q == S_ERROR;

  // Pending covers the first missed cycle in RUN, so the stall is
  // visible the same cycle DataDone fails to arrive.
  assign pend  = ((run && mem_req) || mw) && !DataDone;
  assign flush = !err && !pend && branch_taken;

  assign x_lu = hit_x && load_x && int'(slot_x) < LOAD_READY_SLOT;
  assign y_lu = hit_y && load_y && int'(slot_y) < LOAD_READY_SLOT;
  assign lu   = !err && !pend && !flush && (x_lu || y_lu);

  assign adv       = !err && !pend;
  assign ins_valid = dec_valid && dec_wb && !flush && !lu;

  hazard_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .DEPTH    (DEPTH)
  ) u_sb (
    .clk_i       (Clock),
    .rst_i       (Reset),
    .adv_i       (adv),
    .ins_valid_i (ins_valid),
    .ins_rd_i    (dec_rX),
    .ins_load_i  (dec_load),
    .src_x_i     (dec_rX),
    .use_x_i     (dec_use_x),
    .src_y_i     (dec_rY),
    .use_y_i     (dec_use_y),
    .hit_x_o     (hit_x),
    .load_x_o    (load_x),
    .slot_x_o    (slot_x),
    .hit_y_o     (hit_y),
    .load_y_o    (load_y),
    .slot_y_o    (slot_y)
  );

  assign fwd_x_en   = !Reset && hit_x && !x_lu;
  assign fwd_y_en   = !Reset && hit_y && !y_lu;
  assign fwd_x_slot = slot_x;
  assign fwd_y_slot = slot_y;

  always_comb begin
    stall_vec  = '0;
    bubble_vec = '0;
    if (Reset) begin
      stall_vec  = '0;
    end else if (err) begin
      stall_vec  = '1;
    end else if (pend) begin
      stall_vec[int'(ST_FETCH)]   = 1'b1;
      stall_vec[int'(ST_DECODE)]  = 1'b1;
      stall_vec[int'(ST_EXECUTE)] = 1'b1;
      stall_vec[int'(ST_MEM1)]    = 1'b1;
      bubble_vec[int'(ST_MEM2)]   = 1'b1;
    end else if (flush) begin
      bubble_vec[int'(ST_FETCH)]  = 1'b1;
      bubble_vec[int'(ST_DECODE)] = 1'b1;
    end else if (lu) begin
      stall_vec[int'(ST_FETCH)]    = 1'b1;
      stall_vec[int'(ST_DECODE)]   = 1'b1;
      bubble_vec[int'(ST_EXECUTE)] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    cnt_inc = run ? WB'(1) : cnt_q + WB'(1);
    if (err) begin
      state_d = S_ERROR;
    end else if (pend) begin
      cnt_d = cnt_inc;
      if (cnt_inc == WB'(MAX_WAIT)) begin
        state_d = S_ERROR;
        tmo_d   = 1'b1;
      end else begin
        state_d = S_MEM_WAIT;
      end
    end else begin
      state_d = S_RUN;
      cnt_d   = '0;
    end
  end

  always_comb begin
    scnt_d = scnt_q;
    if (|stall_vec && scnt_q != 16'hFFFF) begin
      scnt_d = scnt_q + 16'd1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      scnt_q  <= scnt_d;
    end
  end

  assign mem_timeout  = tmo_q;
  assign stall_cycles = scnt_q;

endmodule
